// File: rtl/systolic_pe_if.sv
// Port bundle for one systolic_pe tile: configuration, left/top data inputs and
// right/down/partial-sum outputs. The array controller uses master, the PE uses slave.
interface systolic_pe_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
);
    logic                  en;
    logic                  cfg_valid;
    logic                  mode;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] weight;
    logic                  w_valid;
    logic [ACC_WIDTH-1:0]  psum_in;
    logic                  psum_in_valid;
    logic                  drain;
    logic [DATA_WIDTH-1:0] to_right;
    logic                  right_valid;
    logic [DATA_WIDTH-1:0] to_down;
    logic                  down_valid;
    logic [ACC_WIDTH-1:0]  psum_out;
    logic                  psum_out_valid;
    logic                  ovf;
    logic                  collide;

    modport master (
        output en, cfg_valid, mode, in_data, in_valid, weight, w_valid,
               psum_in, psum_in_valid, drain,
        input  to_right, right_valid, to_down, down_valid, psum_out,
               psum_out_valid, ovf, collide
    );

    modport slave (
        input  en, cfg_valid, mode, in_data, in_valid, weight, w_valid,
               psum_in, psum_in_valid, drain,
        output to_right, right_valid, to_down, down_valid, psum_out,
               psum_out_valid, ovf, collide
    );
endinterface

// File: rtl/systolic_pe.sv
// Systolic-array PE with runtime weight-stationary / output-stationary dataflow.
// Optional macro PE_SATURATE_EN: clamp sums to all-ones and raise sticky ovf.
module systolic_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic         clk,
    input  logic         sync_rst,
    systolic_pe_if.slave bus
);
`ifdef PE_SATURATE_EN
    localparam int SUM_W = ACC_WIDTH + 1;
`else
    localparam int SUM_W = ACC_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WS   = 2'd1,
        ST_OS   = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] w_reg, w_next;
    logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
    logic [DATA_WIDTH-1:0] to_right_reg, to_right_next;
    logic                  right_valid_reg, right_valid_next;
    logic [DATA_WIDTH-1:0] to_down_reg, to_down_next;
    logic                  down_valid_reg, down_valid_next;
    logic [ACC_WIDTH-1:0]  psum_out_reg, psum_out_next;
    logic                  psum_out_valid_reg, psum_out_valid_next;
    logic                  ovf_reg, ovf_next;
    logic                  collide_reg, collide_next;

    logic [2*DATA_WIDTH-1:0] ws_prod, os_prod;
    logic [ACC_WIDTH-1:0]    ws_addend;
    logic                    os_mac;
    logic [SUM_W-1:0]        ws_wide, os_wide;
    logic [ACC_WIDTH-1:0]    ws_res, os_res;
    logic                    ws_ovf, os_ovf;

    // WS multiplies by the stored weight; OS by the weight streaming past.
    assign ws_prod   = bus.in_data * w_reg;
    assign os_prod   = bus.in_data * bus.weight;
    assign ws_addend = bus.psum_in_valid ? bus.psum_in : '0;
    assign os_mac    = bus.in_valid && bus.w_valid;
    assign ws_wide   = SUM_W'(ws_addend) + SUM_W'(ws_prod);
    assign os_wide   = SUM_W'(acc_reg) + (os_mac ? SUM_W'(os_prod) : '0);

`ifdef PE_SATURATE_EN
    assign ws_ovf = ws_wide[ACC_WIDTH];
    assign os_ovf = os_wide[ACC_WIDTH];
    assign ws_res = ws_ovf ? '1 : ws_wide[ACC_WIDTH-1:0];
    assign os_res = os_ovf ? '1 : os_wide[ACC_WIDTH-1:0];
`else
    assign ws_ovf = 1'b0;
    assign os_ovf = 1'b0;
    assign ws_res = ws_wide;
    assign os_res = os_wide;
`endif

    always_comb begin
        state_next          = state_reg;
        w_next              = w_reg;
        acc_next            = acc_reg;
        to_right_next       = to_right_reg;
        right_valid_next    = right_valid_reg;
        to_down_next        = to_down_reg;
        down_valid_next     = down_valid_reg;
        psum_out_next       = psum_out_reg;
        psum_out_valid_next = psum_out_valid_reg;
        ovf_next            = ovf_reg;
        collide_next        = collide_reg;

        if (bus.cfg_valid) begin
            // Reconfiguration wipes computation state; data outputs keep their value.
            state_next          = bus.mode ? ST_OS : ST_WS;
            w_next              = '0;
            acc_next            = '0;
            right_valid_next    = 1'b0;
            down_valid_next     = 1'b0;
            psum_out_valid_next = 1'b0;
            ovf_next            = 1'b0;
            collide_next        = 1'b0;
        end else begin
            case (state_reg)
                ST_WS: begin
                    to_right_next    = bus.in_data;
                    right_valid_next = bus.in_valid;
                    if (bus.w_valid) begin
                        w_next          = bus.weight;
                        to_down_next    = w_reg;
                        down_valid_next = 1'b1;
                    end else begin
                        down_valid_next = 1'b0;
                    end
                    if (bus.in_valid) begin
                        psum_out_next       = ws_res;
                        psum_out_valid_next = 1'b1;
                        ovf_next            = ovf_reg | ws_ovf;
                    end else begin
                        psum_out_valid_next = 1'b0;
                    end
                end
                ST_OS: begin
                    to_right_next    = bus.in_data;
                    right_valid_next = bus.in_valid;
                    to_down_next     = bus.weight;
                    down_valid_next  = bus.w_valid;
                    if (os_mac) begin
                        ovf_next = ovf_reg | os_ovf;
                    end
                    if (bus.drain) begin
                        psum_out_next       = os_res;
                        psum_out_valid_next = 1'b1;
                        acc_next            = '0;
                        collide_next        = collide_reg | bus.psum_in_valid;
                    end else begin
                        psum_out_next       = bus.psum_in;
                        psum_out_valid_next = bus.psum_in_valid;
                        acc_next            = os_res;
                    end
                end
                default: begin
                    right_valid_next    = 1'b0;
                    down_valid_next     = 1'b0;
                    psum_out_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_reg          <= ST_IDLE;
            w_reg              <= '0;
            acc_reg            <= '0;
            to_right_reg       <= '0;
            right_valid_reg    <= 1'b0;
            to_down_reg        <= '0;
            down_valid_reg     <= 1'b0;
            psum_out_reg       <= '0;
            psum_out_valid_reg <= 1'b0;
            ovf_reg            <= 1'b0;
            collide_reg        <= 1'b0;
        end else if (bus.en) begin
            state_reg          <= state_next;
            w_reg              <= w_next;
            acc_reg            <= acc_next;
            to_right_reg       <= to_right_next;
            right_valid_reg    <= right_valid_next;
            to_down_reg        <= to_down_next;
            down_valid_reg     <= down_valid_next;
            psum_out_reg       <= psum_out_next;
            psum_out_valid_reg <= psum_out_valid_next;
            ovf_reg            <= ovf_next;
            collide_reg        <= collide_next;
        end
    end

    assign bus.to_right       = to_right_reg;
    assign bus.right_valid    = right_valid_reg;
    assign bus.to_down        = to_down_reg;
    assign bus.down_valid     = down_valid_reg;
    assign bus.psum_out       = psum_out_reg;
    assign bus.psum_out_valid = psum_out_valid_reg;
    assign bus.ovf            = ovf_reg;
    assign bus.collide        = collide_reg;
endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe at DATA_WIDTH=8, ACC_WIDTH=17 (the narrow width
// lets one instance also hit the overflow boundary).
module tb_systolic_pe;
    localparam int DW = 8;
    localparam int AW = 17;

    logic clk = 1'b0;
    logic sync_rst;
    int   checks = 0;
    int   errors = 0;

    systolic_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

    systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.en            = 1'b1;
        bus.cfg_valid     = 1'b0;
        bus.mode          = 1'b0;
        bus.in_data       = '0;
        bus.in_valid      = 1'b0;
        bus.weight        = '0;
        bus.w_valid       = 1'b0;
        bus.psum_in       = '0;
        bus.psum_in_valid = 1'b0;
        bus.drain         = 1'b0;
    endtask

    task automatic configure(input logic m);
        clear_inputs();
        bus.cfg_valid = 1'b1;
        bus.mode      = m;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ovf_psum_exp;
        logic          ovf_flag_exp;
`ifdef PE_SATURATE_EN
        ovf_psum_exp = 17'h1FFFF;
        ovf_flag_exp = 1'b1;
`else
        ovf_psum_exp = 17'h0FE00;
        ovf_flag_exp = 1'b0;
`endif

        // Reset held two cycles with random inputs, including cfg and drain.
        sync_rst          = 1'b1;
        bus.en            = 1'b1;
        bus.cfg_valid     = 1'b1;
        bus.mode          = 1'($urandom_range(0, 1));
        bus.in_data       = DW'($urandom);
        bus.in_valid      = 1'b1;
        bus.weight        = DW'($urandom);
        bus.w_valid       = 1'b1;
        bus.psum_in       = AW'($urandom);
        bus.psum_in_valid = 1'b1;
        bus.drain         = 1'b1;
        step();
        step();
        check("rst_to_right", bus.to_right, 8'd0);
        check("rst_right_valid", bus.right_valid, 1'b0);
        check("rst_to_down", bus.to_down, 8'd0);
        check("rst_down_valid", bus.down_valid, 1'b0);
        check("rst_psum_out", bus.psum_out, 17'd0);
        check("rst_psum_valid", bus.psum_out_valid, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_collide", bus.collide, 1'b0);
        $display("reset: to_right=%0h psum_out=%0h valids=%b%b%b", bus.to_right, bus.psum_out,
                 bus.right_valid, bus.down_valid, bus.psum_out_valid);

        // IDLE ignores activations.
        sync_rst = 1'b0;
        clear_inputs();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd7;
        step();
        check("idle_right_valid", bus.right_valid, 1'b0);
        check("idle_to_right", bus.to_right, 8'd0);
        $display("idle pulse: right_valid=%b to_right=%0h", bus.right_valid, bus.to_right);

        // WS basic MAC.
        configure(1'b0);
        check("cfg_ws_psum_valid", bus.psum_out_valid, 1'b0);
        bus.w_valid = 1'b1;
        bus.weight  = 8'd3;
        step();
        check("ws_load_down_valid", bus.down_valid, 1'b1);
        check("ws_load_to_down", bus.to_down, 8'd0);
        bus.w_valid       = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_data       = 8'd5;
        bus.psum_in       = 17'd15;
        bus.psum_in_valid = 1'b1;
        step();
        check("ws_mac_psum", bus.psum_out, 17'd30);
        check("ws_mac_valid", bus.psum_out_valid, 1'b1);
        check("ws_mac_to_right", bus.to_right, 8'd5);
        check("ws_mac_right_valid", bus.right_valid, 1'b1);
        check("ws_mac_down_valid", bus.down_valid, 1'b0);
        $display("ws mac: psum_out=%0d valid=%b to_right=%0d", bus.psum_out, bus.psum_out_valid, bus.to_right);
        bus.in_valid      = 1'b0;
        bus.psum_in_valid = 1'b0;
        step();
        check("ws_idle_valid", bus.psum_out_valid, 1'b0);
        check("ws_idle_hold", bus.psum_out, 17'd30);
        $display("ws no input: psum_out=%0d valid=%b", bus.psum_out, bus.psum_out_valid);

        // WS weight preload shift chain from a freshly configured PE.
        configure(1'b0);
        bus.w_valid = 1'b1;
        bus.weight  = 8'd9;
        step();
        check("chain_first_to_down", bus.to_down, 8'd0);
        bus.weight = 8'd4;
        step();
        check("chain_second_to_down", bus.to_down, 8'd9);
        $display("ws chain: to_down=%0d", bus.to_down);
        bus.w_valid  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd2;
        step();
        check("chain_wreg_mac", bus.psum_out, 17'd8);
        // Simultaneous weight load and MAC: product uses the old weight (4).
        bus.w_valid = 1'b1;
        bus.weight  = 8'd6;
        bus.in_data = 8'd3;
        step();
        check("ws_same_cycle_psum", bus.psum_out, 17'd12);
        check("ws_same_cycle_to_down", bus.to_down, 8'd4);
        bus.w_valid = 1'b0;
        bus.in_data = 8'd1;
        step();
        check("ws_new_weight_psum", bus.psum_out, 17'd6);
        $display("ws same-cycle load: psum_out=%0d", bus.psum_out);

        // Clock enable low freezes every register.
        bus.en      = 1'b0;
        bus.in_data = 8'd50;
        bus.w_valid = 1'b1;
        bus.weight  = 8'd77;
        step();
        check("en_hold_psum", bus.psum_out, 17'd6);
        check("en_hold_to_right", bus.to_right, 8'd1);
        check("en_hold_down_valid", bus.down_valid, 1'b0);
        $display("en low: psum_out=%0d to_right=%0d", bus.psum_out, bus.to_right);

        // OS accumulate and drain.
        configure(1'b1);
        check("cfg_os_right_valid", bus.right_valid, 1'b0);
        bus.in_valid = 1'b1;
        bus.w_valid  = 1'b1;
        bus.in_data  = 8'd5;
        bus.weight   = 8'd3;
        step();
        check("os_to_down", bus.to_down, 8'd3);
        check("os_down_valid", bus.down_valid, 1'b1);
        check("os_acc_psum_valid", bus.psum_out_valid, 1'b0);
        bus.in_data = 8'd7;
        bus.weight  = 8'd2;
        step();
        bus.in_valid = 1'b0;
        bus.w_valid  = 1'b0;
        bus.drain    = 1'b1;
        step();
        check("os_drain_psum", bus.psum_out, 17'd29);
        check("os_drain_valid", bus.psum_out_valid, 1'b1);
        $display("os drain: psum_out=%0d valid=%b", bus.psum_out, bus.psum_out_valid);
        step();
        check("os_second_drain", bus.psum_out, 17'd0);
        $display("os second drain: psum_out=%0d", bus.psum_out);

        // OS pass-through of an upstream sum.
        bus.drain         = 1'b0;
        bus.psum_in       = 17'd42;
        bus.psum_in_valid = 1'b1;
        step();
        check("os_pass_psum", bus.psum_out, 17'd42);
        check("os_pass_valid", bus.psum_out_valid, 1'b1);
        check("os_pass_collide", bus.collide, 1'b0);
        $display("os pass-through: psum_out=%0d", bus.psum_out);

        // Drain collides with upstream sum; same-cycle MAC is included.
        bus.drain    = 1'b1;
        bus.psum_in  = 17'd100;
        bus.in_valid = 1'b1;
        bus.w_valid  = 1'b1;
        bus.in_data  = 8'd4;
        bus.weight   = 8'd4;
        step();
        check("collide_psum", bus.psum_out, 17'd16);
        check("collide_flag", bus.collide, 1'b1);
        clear_inputs();
        step();
        check("collide_sticky", bus.collide, 1'b1);
        check("collide_after_valid", bus.psum_out_valid, 1'b0);
        $display("os collision: collide=%b", bus.collide);

        // Overflow at the accumulator boundary in WS.
        configure(1'b0);
        check("cfg_clears_collide", bus.collide, 1'b0);
        bus.w_valid = 1'b1;
        bus.weight  = 8'd255;
        step();
        bus.w_valid       = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_data       = 8'd255;
        bus.psum_in       = 17'h1FFFF;
        bus.psum_in_valid = 1'b1;
        step();
        check("ovf_psum", bus.psum_out, ovf_psum_exp);
        check("ovf_flag", bus.ovf, ovf_flag_exp);
        bus.in_data = 8'd1;
        bus.psum_in = 17'd1;
        step();
        check("ovf_small_psum", bus.psum_out, 17'd256);
        check("ovf_sticky", bus.ovf, ovf_flag_exp);
        $display("overflow: psum_out=%0h ovf=%b", bus.psum_out, bus.ovf);
        configure(1'b0);
        check("cfg_clears_ovf", bus.ovf, 1'b0);

        // Reset mid-operation beats drain and enable.
        configure(1'b1);
        bus.in_valid = 1'b1;
        bus.w_valid  = 1'b1;
        bus.in_data  = 8'd10;
        bus.weight   = 8'd10;
        step();
        sync_rst  = 1'b1;
        bus.drain = 1'b1;
        bus.en    = 1'b0;
        step();
        check("midrst_psum", bus.psum_out, 17'd0);
        check("midrst_valid", bus.psum_out_valid, 1'b0);
        check("midrst_to_down", bus.to_down, 8'd0);
        sync_rst = 1'b0;
        clear_inputs();
        bus.in_valid = 1'b1;
        step();
        check("midrst_idle", bus.right_valid, 1'b0);
        $display("mid-op reset: psum_out=%0d valid=%b", bus.psum_out, bus.psum_out_valid);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
